// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter_if : fetch/data requester and memory-side bus signals
// Rev 1.0
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              if_req_i;
  logic [AWIDTH-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DWIDTH-1:0] if_rdata_o;

  logic              dm_req_i;
  logic              dm_we_i;
  logic [AWIDTH-1:0] dm_addr_i;
  logic [DWIDTH-1:0] dm_wdata_i;
  logic [2:0]        dm_funct3_i;
  logic              dm_gnt_o;
  logic              dm_rvalid_o;
  logic [DWIDTH-1:0] dm_rdata_o;

  logic [AWIDTH-1:0] mem_addr_o;
  logic [DWIDTH-1:0] mem_data_o;
  logic              mem_read_en_o;
  logic              mem_write_en_o;
  logic [2:0]        mem_funct3_o;
  logic [DWIDTH-1:0] mem_data_i;

  // Arbiter side
  modport slave (
    input  if_req_i, if_addr_i,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_funct3_i,
    input  mem_data_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    output mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o, mem_funct3_o
  );

  // Requester / memory environment side
  modport master (
    output if_req_i, if_addr_i,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_funct3_i,
    output mem_data_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    input  mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o, mem_funct3_o
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one memory port between fetch and data, data first
// Rev 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int AWIDTH       = 32,
  parameter int DWIDTH       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mem_port_arbiter_if.slave       bus
);
  localparam int             CW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]  C_LIMIT = CW'(STARVE_LIMIT);
  localparam logic [2:0]     C_F3_LW = 3'b010;

  logic [CW-1:0]     r_starve_cnt;
  logic              r_if_rvalid;
  logic              r_dm_rvalid;
  logic [DWIDTH-1:0] r_if_rdata;
  logic [DWIDTH-1:0] r_dm_rdata;

  logic              w_starve;
  logic              w_if_gnt;
  logic              w_dm_gnt;
  logic [AWIDTH-1:0] w_mem_addr;
  logic [DWIDTH-1:0] w_mem_data;
  logic [2:0]        w_mem_f3;
  logic              w_rd_en;
  logic              w_wr_en;

  // Grants are gated by rst_n so nothing reaches memory while reset is held.
  always_comb begin
    w_starve   = (r_starve_cnt == C_LIMIT);
    w_if_gnt   = rst_n & bus.if_req_i & (w_starve | ~bus.dm_req_i);
    w_dm_gnt   = rst_n & bus.dm_req_i & ~w_if_gnt;
    w_mem_addr = '0;
    w_mem_data = '0;
    w_mem_f3   = 3'b000;
    w_rd_en    = 1'b0;
    w_wr_en    = 1'b0;
    if (w_if_gnt) begin
      w_mem_addr = bus.if_addr_i;
      w_mem_f3   = C_F3_LW;
      w_rd_en    = 1'b1;
    end else if (w_dm_gnt) begin
      w_mem_addr = bus.dm_addr_i;
      w_mem_data = bus.dm_wdata_i;
      w_mem_f3   = bus.dm_funct3_i;
      w_rd_en    = ~bus.dm_we_i;
      w_wr_en    = bus.dm_we_i;
    end
  end

  assign bus.if_gnt_o       = w_if_gnt;
  assign bus.dm_gnt_o       = w_dm_gnt;
  assign bus.mem_addr_o     = w_mem_addr;
  assign bus.mem_data_o     = w_mem_data;
  assign bus.mem_funct3_o   = w_mem_f3;
  assign bus.mem_read_en_o  = w_rd_en;
  assign bus.mem_write_en_o = w_wr_en;
  assign bus.if_rvalid_o    = r_if_rvalid;
  assign bus.if_rdata_o     = r_if_rdata;
  assign bus.dm_rvalid_o    = r_dm_rvalid;
  assign bus.dm_rdata_o     = r_dm_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_rvalid  <= 1'b0;
      r_dm_rvalid  <= 1'b0;
      r_if_rdata   <= '0;
      r_dm_rdata   <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_if_rvalid <= w_if_gnt;
      r_dm_rvalid <= w_dm_gnt;
      if (w_if_gnt) begin
        r_if_rdata <= bus.mem_data_i;
      end
      if (w_dm_gnt) begin
        r_dm_rdata <= bus.dm_we_i ? '0 : bus.mem_data_i;
      end
      // Counts DM wins that overtook a waiting fetch; any fetch grant or idle fetch clears it.
      if (w_if_gnt || !bus.if_req_i) begin
        r_starve_cnt <= '0;
      end else if (w_dm_gnt && !w_starve) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : random + directed checks against a fairness/memory model
// Rev 1.0
// ============================================================================
module tb_mem_port_arbiter;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

  mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .STARVE_LIMIT(LIM)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] mem [0:1023];
  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: how many data grants have overtaken the waiting fetch
  int          m_wait = 0;
  logic [31:0] m_ird  = '0;
  logic [31:0] m_drd  = '0;
  logic        g_if   = 1'b0;
  logic        g_dm   = 1'b0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] w;
    w = {mem[10'(a + 32'd3)], mem[10'(a + 32'd2)], mem[10'(a + 32'd1)], mem[a[9:0]]};
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'h0, w[7:0]};
      3'b101:  return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    int n;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    for (int i = 0; i < n; i++) mem[10'(a + 32'(i))] = d[8*i +: 8];
  endtask

  assign bus.mem_data_i = mem_rd(bus.mem_addr_o, bus.mem_funct3_o);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a negedge with the cycle's request inputs already applied.
  task automatic cyc();
    logic e_if, e_dm, we;
    logic [31:0] e_ird, e_drd;
    #1;
    we    = bus.dm_we_i;
    e_if  = bus.if_req_i && (m_wait == LIM || !bus.dm_req_i);
    e_dm  = bus.dm_req_i && !e_if;
    e_ird = mem_rd(bus.if_addr_i, 3'b010);
    e_drd = we ? 32'h0 : mem_rd(bus.dm_addr_i, bus.dm_funct3_i);
    check("if_gnt", bus.if_gnt_o, e_if);
    check("dm_gnt", bus.dm_gnt_o, e_dm);
    check("rd_en", bus.mem_read_en_o, e_if || (e_dm && !we));
    check("wr_en", bus.mem_write_en_o, e_dm && we);
    check("mem_addr", bus.mem_addr_o, e_if ? bus.if_addr_i : e_dm ? bus.dm_addr_i : 32'h0);
    check("mem_f3", bus.mem_funct3_o, e_if ? 3'b010 : e_dm ? bus.dm_funct3_i : 3'b000);
    check("mem_wdata", bus.mem_data_o, (e_dm && !e_if) ? bus.dm_wdata_i : 32'h0);
    if (bus.mem_write_en_o) mem_wr(bus.mem_addr_o, bus.mem_funct3_o, bus.mem_data_o);
    if (e_if || !bus.if_req_i) m_wait = 0;
    else if (e_dm && m_wait < LIM) m_wait++;
    if (e_if) m_ird = e_ird;
    if (e_dm) m_drd = e_drd;
    g_if = e_if;
    g_dm = e_dm;
    @(posedge clk);
    #1;
    check("if_rvalid", bus.if_rvalid_o, e_if);
    check("if_rdata", bus.if_rdata_o, m_ird);
    check("dm_rvalid", bus.dm_rvalid_o, e_dm);
    check("dm_rdata", bus.dm_rdata_o, m_drd);
    @(negedge clk);
  endtask

  task automatic set_if(input logic req, input logic [31:0] a);
    bus.if_req_i  = req;
    bus.if_addr_i = a;
  endtask

  task automatic set_dm(input logic req, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f3);
    bus.dm_req_i    = req;
    bus.dm_we_i     = we;
    bus.dm_addr_i   = a;
    bus.dm_wdata_i  = d;
    bus.dm_funct3_i = f3;
  endtask

  initial begin
    logic [4:0]  seq;
    logic [31:0] r;
    int          dm_run;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    set_if(1'b0, 32'h0);
    set_dm(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    @(negedge clk);
    #1;
    check("rst_if_gnt", bus.if_gnt_o, 1'b0);
    check("rst_if_rvalid", bus.if_rvalid_o, 1'b0);
    check("rst_dm_rvalid", bus.dm_rvalid_o, 1'b0);
    check("rst_dm_rdata", bus.dm_rdata_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fetch alone, then data store followed by byte load of the stored word
    set_if(1'b1, 32'h0100_0000);
    cyc();
    set_if(1'b0, 32'h0);
    set_dm(1'b1, 1'b1, 32'h0100_0100, 32'hCAFE_F00D, 3'b010);
    cyc();
    set_dm(1'b1, 1'b0, 32'h0100_0101, 32'h0, 3'b100);
    cyc();
    check("lbu_value", bus.dm_rdata_o, 32'h0000_00F0);

    // Contention: four data grants, then the fetch, then data again
    seq = '0;
    set_if(1'b1, 32'h0100_0010);
    set_dm(1'b1, 1'b0, 32'h0100_0020, 32'h0, 3'b010);
    for (int i = 0; i < 5; i++) begin
      cyc();
      seq = {seq[3:0], g_if};
      if (g_if) set_if(1'b1, 32'h0100_0014);
    end
    check("contention_seq", seq, 5'b00001);
    cyc();
    check("dm_after_if", g_dm, 1'b1);

    // Fetch dropped while pending restarts the starvation window
    set_if(1'b0, 32'h0);
    cyc();
    set_if(1'b1, 32'h0100_0018);
    dm_run = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (g_dm) dm_run++;
    end
    check("dm_run_after_drop", dm_run, 4);

    // Reset asserted between edges with a store and fetch both requesting
    set_if(1'b1, 32'h0100_0030);
    set_dm(1'b1, 1'b1, 32'h0100_0040, 32'h1234_5678, 3'b010);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_if_gnt", bus.if_gnt_o, 1'b0);
    check("rst_mid_dm_gnt", bus.dm_gnt_o, 1'b0);
    check("rst_mid_wr_en", bus.mem_write_en_o, 1'b0);
    check("rst_mid_rd_en", bus.mem_read_en_o, 1'b0);
    @(posedge clk);
    #1;
    check("rst_mid_if_rvalid", bus.if_rvalid_o, 1'b0);
    check("rst_mid_dm_rvalid", bus.dm_rvalid_o, 1'b0);
    @(negedge clk);
    rst_n  = 1'b1;
    m_wait = 0;
    m_ird  = '0;
    m_drd  = '0;
    cyc();
    cyc();

    // Idle window
    set_if(1'b0, 32'h0);
    set_dm(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    for (int i = 0; i < 10; i++) cyc();

    // Random traffic: requesters hold until granted, occasionally give up
    for (int i = 0; i < 500; i++) begin
      if (!bus.if_req_i || g_if) begin
        r = 32'h0100_0000 + {20'h0, 10'($urandom_range(0, 255) * 4), 2'b00} % 32'd1024;
        set_if($urandom_range(0, 3) != 0, r);
      end else if ($urandom_range(0, 15) == 0) begin
        bus.if_req_i = 1'b0;
      end
      if (!bus.dm_req_i || g_dm) begin
        logic       we;
        logic [2:0] f3;
        we = 1'($urandom);
        case ($urandom_range(0, 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = we ? 3'b010 : 3'b100;
          default: f3 = we ? 3'b001 : 3'b101;
        endcase
        r = 32'h0100_0000 + 32'($urandom_range(0, 255) * 4);
        if (f3[1:0] == 2'b00) r = r + 32'($urandom_range(0, 3));
        else if (f3[1:0] == 2'b01) r = r + 32'($urandom_range(0, 1) * 2);
        set_dm($urandom_range(0, 3) != 0, we, r, $urandom, f3);
      end else if ($urandom_range(0, 15) == 0) begin
        bus.dm_req_i = 1'b0;
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
